// File: rtl/gpr_read_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_read_arbiter
//
// Shares the banked GPR read ports of one issue slice between several
// operand-collector requesters. Every cycle each bank grants at most one read,
// picked round-robin from the requesters that target it. The bank RAM address
// is driven in the grant cycle. The synchronous RAM output is routed back to
// the winning requester exactly one cycle later.
//
// Parameters
//   NUM_REQS   number of requesters (>= 1)
//   NUM_BANKS  number of GPR banks (power of 2, >= 1)
//   NR_BITS    register id width
//   WIS_BITS   warp-in-slice index width (0 => no wis field in the address)
//   DATAW      read data width per bank
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   req_valid      per-requester read request valid
//   req_rid        per-requester register id (NR_BITS each)
//   req_wis        per-requester warp-in-slice index (max(WIS_BITS,1) each)
//   req_ready      request granted this cycle (combinational)
//   rsp_valid      read data valid for requester (cycle after grant)
//   rsp_data       read data per requester, zero when not responding
//   bank_rd_en     per-bank read strobe (combinational)
//   bank_rd_addr   per-bank address {wis, rid[NR_BITS-1:BANK_BITS]}
//   bank_rd_data   per-bank RAM output, valid one cycle after the strobe
//   perf_stalls    count of cycles with at least one valid-but-not-ready request
//
// Build option
//   GPR_ARB_PERF_EN  when defined, perf_stalls is a 32-bit wrapping counter
//                    cleared by reset; otherwise perf_stalls is tied to zero
//                    and no counter flops exist.
// -----------------------------------------------------------------------------
module gpr_read_arbiter #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 2,
  parameter int NR_BITS   = 6,
  parameter int WIS_BITS  = 2,
  parameter int DATAW     = 128
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQS-1:0]                        req_valid,
  input  logic [NUM_REQS*NR_BITS-1:0]                req_rid,
  input  logic [NUM_REQS*((WIS_BITS > 0) ? WIS_BITS : 1)-1:0] req_wis,
  output logic [NUM_REQS-1:0]                        req_ready,
  output logic [NUM_REQS-1:0]                        rsp_valid,
  output logic [NUM_REQS*DATAW-1:0]                  rsp_data,
  output logic [NUM_BANKS-1:0]                       bank_rd_en,
  output logic [NUM_BANKS*(WIS_BITS+NR_BITS-$clog2(NUM_BANKS))-1:0] bank_rd_addr,
  input  logic [NUM_BANKS*DATAW-1:0]                 bank_rd_data,
  output logic [31:0]                                perf_stalls
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BKW       = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int WISW      = (WIS_BITS > 0) ? WIS_BITS : 1;
  localparam int ADDRW     = WIS_BITS + NR_BITS - BANK_BITS;
  localparam int PTRW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  // ---------------------------------------------------------------------------
  // Per-requester decode: target bank and bank-local address.
  // ---------------------------------------------------------------------------
  logic [BKW-1:0]   req_bank [NUM_REQS];
  logic [ADDRW-1:0] req_addr [NUM_REQS];

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
    if (BANK_BITS > 0) begin : g_bank_sel
      assign req_bank[gi] = req_rid[gi*NR_BITS +: BKW];
    end else begin : g_single_bank
      assign req_bank[gi] = '0;
    end

    if (WIS_BITS > 0) begin : g_addr_wis
      assign req_addr[gi] = {req_wis[gi*WISW +: WISW],
                             req_rid[gi*NR_BITS+BANK_BITS +: NR_BITS-BANK_BITS]};
    end else begin : g_addr_nowis
      assign req_addr[gi] = req_rid[gi*NR_BITS+BANK_BITS +: NR_BITS-BANK_BITS];
    end
  end

  // With no wis field the wis port carries one unused bit per requester.
  if (WIS_BITS == 0) begin : g_no_wis
    logic unused_wis;
    assign unused_wis = ^req_wis;
  end

  // ---------------------------------------------------------------------------
  // Per-bank round-robin arbitration and response ownership.
  // ---------------------------------------------------------------------------
  logic [NUM_BANKS-1:0] grant_vld;
  logic [PTRW-1:0]      grant_idx      [NUM_BANKS];
  logic                 bank_rsp_vld   [NUM_BANKS];
  logic [PTRW-1:0]      bank_rsp_owner [NUM_BANKS];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic            found;
    logic [PTRW-1:0] win;
    logic [PTRW-1:0] ptr_reg;
    logic [PTRW-1:0] ptr_next;
    logic            own_vld_reg;
    logic [PTRW-1:0] owner_reg;

    // Scan requesters starting at the pointer; the first valid requester
    // that targets this bank wins. Only one winner per bank is possible, so
    // two requesters can never share a bank in a cycle, whatever the inputs.
    always_comb begin : p_search
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int off = 0; off < NUM_REQS; off++) begin
        idx = int'(ptr_reg) + off;
        if (idx >= NUM_REQS) begin
          idx = idx - NUM_REQS;
        end
        if (!found && req_valid[idx] && (req_bank[idx] == BKW'(gi))) begin
          found = 1'b1;
          win   = PTRW'(idx);
        end
      end
    end

    // No grants are issued while reset is high.
    assign grant_vld[gi] = found & ~reset;
    assign grant_idx[gi] = win;
    assign ptr_next      = (win == PTRW'(NUM_REQS-1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
      if (reset) begin
        ptr_reg     <= '0;
        own_vld_reg <= 1'b0;
        owner_reg   <= '0;
      end else begin
        own_vld_reg <= found;
        owner_reg   <= win;
        if (found) begin
          ptr_reg <= ptr_next;
        end
      end
    end

    assign bank_rd_en[gi]                   = grant_vld[gi];
    assign bank_rd_addr[gi*ADDRW +: ADDRW]  = grant_vld[gi] ? req_addr[win] : '0;
    assign bank_rsp_vld[gi]                 = own_vld_reg;
    assign bank_rsp_owner[gi]               = owner_reg;
  end

  // ---------------------------------------------------------------------------
  // Grant fan-in: a requester targets a single bank, so it can appear as the
  // winner of at most one bank.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (grant_vld[b]) begin
        req_ready[grant_idx[b]] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing. The owner registers describe last cycle's grants; the
  // RAM data for those grants is on bank_rd_data now. A response that lands
  // in a reset cycle is dropped. Owners of different banks are distinct in
  // any one cycle, so plain assignment is enough.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_rsp_vld[b] && !reset) begin
        rsp_valid[bank_rsp_owner[b]] = 1'b1;
        rsp_data[int'(bank_rsp_owner[b])*DATAW +: DATAW] = bank_rd_data[b*DATAW +: DATAW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Conflict-stall counter.
  // ---------------------------------------------------------------------------
`ifdef GPR_ARB_PERF_EN
  logic [31:0] perf_stalls_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_reg <= '0;
    end else if (|(req_valid & ~req_ready)) begin
      perf_stalls_reg <= perf_stalls_reg + 32'd1;
    end
  end

  assign perf_stalls = perf_stalls_reg;
`else
  assign perf_stalls = '0;
`endif

endmodule
